// File: rtl/hazard_unit_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_mc
//  Purpose  : Pipeline hazard unit with operand forwarding, load-use stalls
//             (LOAD_STALL cycles), multi-cycle mul/div hold and branch flush.
//             Keeps a saturating count of fetch-stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,   // legal range 1..3
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              ResultSrcE,
  input  logic              RegWriteE,
  input  logic              PcSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MdStartE,
  input  logic              MdDoneE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [CNT_W-1:0]  StallCount
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_LDSTALL = 2'd1;
  localparam logic [1:0] c_MDBUSY  = 2'd2;
  // Remaining load stall cycles after the first one, taken in IDLE.
  localparam logic [1:0] c_LD_INIT = 2'(LOAD_STALL - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_ldcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [1:0]       w_state_nxt;
  logic [1:0]       w_ldcnt_nxt;
  logic             w_lduse;
  logic             w_md_start;
  logic             w_ld_hold;
  logic             w_md_hold;

  // RegWriteE does not influence any hazard decision in this pipeline;
  // it is part of the port set so E-stage write intent stays visible here.
  logic w_unused;
  assign w_unused = RegWriteE;

  // A load in E whose destination feeds an instruction in D.
  assign w_lduse = ResultSrcE & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));

  // A mul/div may only start when E holds neither a load nor a taken branch.
  assign w_md_start = MdStartE & ~ResultSrcE & ~PcSrcE;

  // Operand forwarding: M has priority over W, x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && (RdM == Rs1E) && (Rs1E != '0))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW == Rs1E) && (Rs1E != '0)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM == Rs2E) && (Rs2E != '0))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW == Rs2E) && (Rs2E != '0)) ForwardBE = 2'b01;
    end
  end

  // FSM state and load-stall down-counter; reset abandons any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_ldcnt <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ldcnt <= w_ldcnt_nxt;
    end
  end

  // Next-state and down-counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_ldcnt_nxt = r_ldcnt;
    case (r_state)
      c_IDLE: begin
        if (w_lduse) begin
          if (LOAD_STALL > 1) begin
            w_state_nxt = c_LDSTALL;
            w_ldcnt_nxt = c_LD_INIT;
          end
        end else if (w_md_start) begin
          w_state_nxt = c_MDBUSY;
        end
      end
      c_LDSTALL: begin
        w_ldcnt_nxt = r_ldcnt - 2'd1;
        if (r_ldcnt == 2'd1) w_state_nxt = c_IDLE;
      end
      c_MDBUSY: begin
        if (MdDoneE) w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_ldcnt_nxt = 2'd0;
      end
    endcase
  end

  // Stall/flush outputs; branch flush is independent of the stall state.
  always_comb begin
    w_ld_hold = 1'b0;
    w_md_hold = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_ld_hold = w_lduse;
        w_md_hold = w_md_start;
      end
      c_LDSTALL: w_ld_hold = 1'b1;
      c_MDBUSY:  w_md_hold = ~MdDoneE;
      default: begin
        w_ld_hold = 1'b0;
        w_md_hold = 1'b0;
      end
    endcase
    stallF = ~reset & (w_ld_hold | w_md_hold);
    stallD = ~reset & (w_ld_hold | w_md_hold);
    stallE = ~reset & w_md_hold;
    FlushM = ~reset & w_md_hold;
    FlushE = ~reset & (w_ld_hold | PcSrcE);
    FlushD = ~reset & PcSrcE;
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stallF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit_mc
//  Purpose  : Scoreboard bench for hazard_unit_mc. Main instance uses
//             LOAD_STALL=3 / CNT_W=16, a second uses LOAD_STALL=1 / CNT_W=4
//             on the same inputs to exercise the single-cycle load stall and
//             counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit_mc;

  // Flag order: {stallF, stallD, stallE, FlushD, FlushE, FlushM}
  localparam logic [5:0] c_NONE = 6'b000000;
  localparam logic [5:0] c_LD   = 6'b110010;
  localparam logic [5:0] c_MD   = 6'b111001;
  localparam logic [5:0] c_BR   = 6'b000110;
  localparam logic [5:0] c_LDBR = 6'b110110;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE, RegWriteE, PcSrcE, RegWriteM, RegWriteW, MdStartE, MdDoneE;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        stallF, stallD, stallE, FlushD, FlushE, FlushM;
  logic [15:0] StallCount;

  logic [1:0]  fa4, fb4;
  logic        stallF4, stallD4, stallE4, flushD4, flushE4, flushM4;
  logic [3:0]  StallCount4;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PcSrcE(PcSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .StallCount(StallCount)
  );

  hazard_unit_mc #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PcSrcE(PcSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .ForwardAE(fa4), .ForwardBE(fb4),
    .stallF(stallF4), .stallD(stallD4), .stallE(stallE4),
    .FlushD(flushD4), .FlushE(flushE4), .FlushM(flushM4),
    .StallCount(StallCount4)
  );

  // Scoreboard entry: {fa[1:0], fb[1:0], flags[5:0], stallF4, cnt16, cnt4}
  logic [30:0] sb_q[$];
  string       nm_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] cnt_m  = '0;
  logic [3:0]  cnt4   = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 1'b0; RegWriteE = 1'b0; PcSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MdStartE = 1'b0; MdDoneE = 1'b0;
  endtask

  // Queue the expected response for the current cycle, then advance the
  // expected stall counters by this cycle's fetch stall.
  task automatic expect_cyc(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [5:0] fl, input logic sf4);
    if (reset) begin
      cnt_m = '0;
      cnt4  = '0;
    end
    sb_q.push_back({fa, fb, fl, sf4, cnt_m, cnt4});
    nm_q.push_back(nm);
    if (fl[5]) cnt_m = cnt_m + 16'd1;
    if (sf4 && (cnt4 != 4'hF)) cnt4 = cnt4 + 4'd1;
  endtask

  // Monitor: compare DUT outputs mid-cycle whenever an expectation is pending.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      logic [30:0] e;
      logic [10:0] act_f;
      logic [19:0] act_c;
      string       nm;
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      act_f = {ForwardAE, ForwardBE, stallF, stallD, stallE, FlushD, FlushE, FlushM, stallF4};
      act_c = {StallCount, StallCount4};
      n_chk++;
      if (act_f === e[30:20]) n_pass++;
      else $display("FAIL %s flags: got %b want %b", nm, act_f, e[30:20]);
      n_chk++;
      if (act_c === e[19:0]) n_pass++;
      else $display("FAIL %s count: got %0d/%0d want %0d/%0d",
                    nm, act_c[19:4], act_c[3:0], e[19:4], e[3:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clr();

    // Reset forces everything low regardless of inputs.
    tick();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; PcSrcE = 1'b1;
    ResultSrcE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; MdStartE = 1'b1;
    expect_cyc("rst_hold", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); reset = 1'b0; clr();
    expect_cyc("post_rst", 2'b00, 2'b00, c_NONE, 1'b0);

    // Forwarding
    tick(); clr(); Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd9;
    expect_cyc("fwd_m_prio", 2'b10, 2'b00, c_NONE, 1'b0);
    tick(); RdW = 5'd9;
    expect_cyc("fwd_b_w", 2'b10, 2'b01, c_NONE, 1'b0);
    tick(); clr(); Rs1E = '0; Rs2E = '0; RdM = '0; RegWriteM = 1'b1; RdW = '0; RegWriteW = 1'b1;
    expect_cyc("fwd_x0", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); clr(); Rs1E = 5'd7; Rs2E = 5'd7; RdM = 5'd7; RegWriteM = 1'b0; RdW = 5'd7; RegWriteW = 1'b1;
    expect_cyc("fwd_w_both", 2'b01, 2'b01, c_NONE, 1'b0);
    tick(); clr(); Rs1E = 5'd12; Rs2E = 5'd12; RdM = 5'd12; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1;
    expect_cyc("fwd_m_both", 2'b10, 2'b10, c_NONE, 1'b0);
    tick(); clr(); Rs1E = 5'd4; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd4; RegWriteW = 1'b0;
    expect_cyc("fwd_none", 2'b00, 2'b00, c_NONE, 1'b0);

    // Load-use: 3 stall cycles on the main DUT, 1 on the LOAD_STALL=1 copy
    tick(); clr(); ResultSrcE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    expect_cyc("ld_c1", 2'b00, 2'b00, c_LD, 1'b1);
    tick(); clr();
    expect_cyc("ld_c2", 2'b00, 2'b00, c_LD, 1'b0);
    tick();
    expect_cyc("ld_c3", 2'b00, 2'b00, c_LD, 1'b0);
    tick();
    expect_cyc("ld_done", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); clr(); ResultSrcE = 1'b1; RdE = '0; Rs1D = '0;
    expect_cyc("ld_rd0", 2'b00, 2'b00, c_NONE, 1'b0);

    // Mul/div: start + 3 busy cycles stalled, released on MdDoneE
    tick(); clr(); MdStartE = 1'b1; Rs1E = 5'd6; RdM = 5'd6; RegWriteM = 1'b1;
    expect_cyc("md_start", 2'b10, 2'b00, c_MD, 1'b1);
    tick(); MdStartE = 1'b0;
    expect_cyc("md_busy1", 2'b10, 2'b00, c_MD, 1'b1);
    tick(); RegWriteM = 1'b0; RdW = 5'd6; RegWriteW = 1'b1;
    expect_cyc("md_busy2", 2'b01, 2'b00, c_MD, 1'b1);
    tick(); RegWriteM = 1'b1;
    expect_cyc("md_busy3", 2'b10, 2'b00, c_MD, 1'b1);
    tick(); MdDoneE = 1'b1;
    expect_cyc("md_done", 2'b10, 2'b00, c_NONE, 1'b0);
    tick(); clr();
    expect_cyc("md_after", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); clr(); MdStartE = 1'b1; ResultSrcE = 1'b1;
    expect_cyc("md_ign_load", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); clr();
    expect_cyc("md_ign_after", 2'b00, 2'b00, c_NONE, 1'b0);

    // Branch
    tick(); clr(); PcSrcE = 1'b1;
    expect_cyc("br_only", 2'b00, 2'b00, c_BR, 1'b0);
    tick(); clr(); PcSrcE = 1'b1; ResultSrcE = 1'b1; RdE = 5'd8; Rs2D = 5'd8;
    expect_cyc("br_lduse", 2'b00, 2'b00, c_LDBR, 1'b1);
    tick(); clr();
    expect_cyc("br_ld_c2", 2'b00, 2'b00, c_LD, 1'b0);
    tick();
    expect_cyc("br_ld_c3", 2'b00, 2'b00, c_LD, 1'b0);
    tick(); clr(); PcSrcE = 1'b1; MdStartE = 1'b1;
    expect_cyc("br_md", 2'b00, 2'b00, c_BR, 1'b0);
    tick(); clr();
    expect_cyc("br_md_after", 2'b00, 2'b00, c_NONE, 1'b0);

    // Reset in the second MDBUSY cycle
    tick(); clr(); MdStartE = 1'b1;
    expect_cyc("rmd_start", 2'b00, 2'b00, c_MD, 1'b1);
    tick(); clr();
    expect_cyc("rmd_busy1", 2'b00, 2'b00, c_MD, 1'b1);
    tick(); reset = 1'b1;
    expect_cyc("rmd_reset", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); reset = 1'b0;
    expect_cyc("rmd_rel1", 2'b00, 2'b00, c_NONE, 1'b0);
    tick();
    expect_cyc("rmd_rel2", 2'b00, 2'b00, c_NONE, 1'b0);

    // Long MDBUSY: 4-bit counter saturates at 15
    tick(); clr(); MdStartE = 1'b1;
    expect_cyc("sat_start", 2'b00, 2'b00, c_MD, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(); MdStartE = 1'b0;
      expect_cyc("sat_busy", 2'b00, 2'b00, c_MD, 1'b1);
    end
    tick(); MdDoneE = 1'b1;
    expect_cyc("sat_done", 2'b00, 2'b00, c_NONE, 1'b0);
    tick(); clr();
    expect_cyc("sat_final", 2'b00, 2'b00, c_NONE, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
